// File: rtl/lock_in_amplifier.sv
// Lock-in amplifier: multiply the measured signal by the reference(s), integrate-and-dump over
// 2^ACC_LOG2 samples, scale and saturate. Define LIA_QUADRATURE_EN to build the Q path and output magnitude.
module lock_in_amplifier #(
  parameter int ACC_LOG2 = 10
) (
  input  logic               dac_clk_i,
  input  logic               dac_rstn_i,
  input  logic signed [13:0] adcInputChannel1,
  input  logic signed [13:0] inPhase,
  input  logic signed [13:0] outPhase,
  output logic signed [13:0] LIAOutput_O,
  output logic               lia_valid_o
);

  localparam int ACC_W = 28 + ACC_LOG2;

  logic signed [13:0]       adc_r, in_r;
  logic signed [27:0]       prod_i;
  logic signed [ACC_W-1:0]  acc_i, sum_i;
  logic signed [14:0]       win_i;
  logic [ACC_LOG2-1:0]      cnt;
  logic                     fill_1, fill_2, dump_r;
  logic signed [13:0]       result;

  // Window sum including the current product; its top 15 bits are exactly sum >>> (ACC_LOG2+13).
  assign sum_i = acc_i + ACC_W'(prod_i);

`ifdef LIA_QUADRATURE_EN
  logic signed [13:0]       out_r;
  logic signed [27:0]       prod_q;
  logic signed [ACC_W-1:0]  acc_q, sum_q;
  logic signed [14:0]       win_q;

  assign sum_q = acc_q + ACC_W'(prod_q);
`else
  logic unused_out_phase;
  assign unused_out_phase = ^outPhase;
`endif

  // NOTE: every register here, accumulators included, uses non-blocking assignment so all
  // stages sample the previous cycle's values regardless of statement order.
  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      adc_r  <= '0;
      in_r   <= '0;
      prod_i <= '0;
      acc_i  <= '0;
      win_i  <= '0;
      cnt    <= '0;
      fill_1 <= 1'b0;
      fill_2 <= 1'b0;
      dump_r <= 1'b0;
`ifdef LIA_QUADRATURE_EN
      out_r  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      win_q  <= '0;
`endif
    end else begin
      adc_r  <= adcInputChannel1;
      in_r   <= inPhase;
      fill_1 <= 1'b1;
      prod_i <= adc_r * in_r;
      fill_2 <= fill_1;
      dump_r <= fill_2 && (&cnt);
`ifdef LIA_QUADRATURE_EN
      out_r  <= outPhase;
      prod_q <= adc_r * out_r;
`endif
      // Counting starts with the first real product so no window is built from pipeline fill.
      if (fill_2) begin
        cnt   <= cnt + 1'b1;
        acc_i <= (cnt == '0) ? ACC_W'(prod_i) : sum_i;
`ifdef LIA_QUADRATURE_EN
        acc_q <= (cnt == '0) ? ACC_W'(prod_q) : sum_q;
`endif
        if (&cnt) begin
          win_i <= sum_i[ACC_W-1 -: 15];
`ifdef LIA_QUADRATURE_EN
          win_q <= sum_q[ACC_W-1 -: 15];
`endif
        end
      end
    end
  end

`ifdef LIA_QUADRATURE_EN
  logic [14:0] abs_i, abs_q, mag_max, mag_min;
  logic [15:0] mag;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    abs_i   = win_i[14] ? 15'(-win_i) : 15'(win_i);
    abs_q   = win_q[14] ? 15'(-win_q) : 15'(win_q);
    mag_max = (abs_i > abs_q) ? abs_i : abs_q;
    mag_min = (abs_i > abs_q) ? abs_q : abs_i;
    mag     = {1'b0, mag_max} + {2'b00, mag_min[14:1]};
    result  = (mag > 16'd8191) ? 14'sd8191 : signed'(mag[13:0]);
  end
`else
  always_comb begin
    result = win_i[13:0];
    if (win_i > 15'sd8191)
      result = 14'sd8191;
    else if (win_i < -15'sd8192)
      result = -14'sd8192;
  end
`endif

  always_ff @(posedge dac_clk_i) begin
    if (!dac_rstn_i) begin
      LIAOutput_O <= '0;
      lia_valid_o <= 1'b0;
    end else begin
      lia_valid_o <= dump_r;
      if (dump_r)
        LIAOutput_O <= result;
    end
  end

endmodule

// File: tb/tb_lock_in_amplifier.sv
// Randomized plus directed bench for lock_in_amplifier (ACC_LOG2 = 4) against a window-sum model;
// follows LIA_QUADRATURE_EN the same way the design does.
module tb_lock_in_amplifier;

  localparam int ACC_LOG2 = 4;
  localparam int N        = 16;
  localparam int LATENCY  = N + 2;
  localparam int NO_LIT   = -99999;

  logic               dac_clk_i = 1'b0;
  logic               dac_rstn_i;
  logic signed [13:0] adc, in_ph, out_ph;
  logic signed [13:0] lia_out;
  logic               lia_valid;

  int      n_checks = 0;
  int      n_fail   = 0;
  longint  prod_i_q[$];
  longint  prod_q_q[$];
  int      k;
  longint  exp_out;
  bit      exp_valid;

  always #5 dac_clk_i = ~dac_clk_i;

  lock_in_amplifier #(.ACC_LOG2(ACC_LOG2)) dut (
    .dac_clk_i        (dac_clk_i),
    .dac_rstn_i       (dac_rstn_i),
    .adcInputChannel1 (adc),
    .inPhase          (in_ph),
    .outPhase         (out_ph),
    .LIAOutput_O      (lia_out),
    .lia_valid_o      (lia_valid)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at window edge %0d: got %0d, expected %0d", name, k, act, req);
    end
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q = s / d;
    if ((s % d) != 0 && s < 0) q -= 1;
    return q;
  endfunction

  function automatic longint window_value(input int w);
    longint si = 0, sq = 0, vi, vq, ai, aq, mx, mn, m;
    for (int j = 0; j < N; j++) begin
      si += prod_i_q[w*N + j];
      sq += prod_q_q[w*N + j];
    end
    vi = floor_div(si, longint'(1) << (ACC_LOG2 + 13));
    vq = floor_div(sq, longint'(1) << (ACC_LOG2 + 13));
`ifdef LIA_QUADRATURE_EN
    ai = (vi < 0) ? -vi : vi;
    aq = (vq < 0) ? -vq : vq;
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    m  = mx + mn / 2;
    return (m > 8191) ? 8191 : m;
`else
    ai = vq; aq = 0; mx = 0; mn = 0; m = ai;
    if (vi > 8191) return 8191;
    if (vi < -8192) return -8192;
    return vi;
`endif
  endfunction

  // One clock: drive inputs, advance the model, compare outputs 1 time unit after the edge.
  task automatic step(input bit rst, input int a, input int i, input int o, input int lit);
    adc        = 14'(a);
    in_ph      = 14'(i);
    out_ph     = 14'(o);
    dac_rstn_i = !rst;
    @(posedge dac_clk_i);
    #1;
    if (rst) begin
      prod_i_q.delete();
      prod_q_q.delete();
      k         = -1;
      exp_out   = 0;
      exp_valid = 1'b0;
    end else begin
      k++;
      prod_i_q.push_back(longint'(a) * longint'(i));
      prod_q_q.push_back(longint'(a) * longint'(o));
      exp_valid = (k >= LATENCY) && ((k - LATENCY) % N == 0);
      if (exp_valid) exp_out = window_value((k - LATENCY) / N);
    end
    check("lia_valid_o", longint'(lia_valid), longint'(exp_valid));
    check("LIAOutput_O", longint'(lia_out), exp_out);
    if (exp_valid && lit != NO_LIT)
      check("literal_output", longint'(lia_out), longint'(lit));
  endtask

  task automatic run_const(input int a, input int i, input int o, input int lit, input int n_win);
    step(1'b1, 0, 0, 0, NO_LIT);
    step(1'b1, 0, 0, 0, NO_LIT);
    for (int c = 0; c < LATENCY + N*n_win; c++)
      step(1'b0, a, i, o, lit);
  endtask

  function automatic int rnd14();
    case ($urandom_range(0, 5))
      0:       return -8192;
      1:       return 8191;
      default: return int'($urandom_range(0, 16383)) - 8192;
    endcase
  endfunction

  initial begin
    k = -1;
    exp_out = 0;
    exp_valid = 1'b0;
    for (int c = 0; c < 3; c++) step(1'b1, 1234, -77, 55, NO_LIT);

    run_const(4096, 8191, 0, 4095, 3);
`ifdef LIA_QUADRATURE_EN
    run_const(4096, 0, -8192, 4096, 2);
    run_const(4096, 8191, 8191, 6142, 2);
`else
    run_const(4096, 0, -8192, 0, 2);
    run_const(4096, 8191, 8191, 4095, 2);
    run_const(-8192, 8191, 0, -8191, 2);
`endif
    run_const(-8192, -8192, 0, 8191, 2);

    // Reset pulsed at cycle 7 of a window: partial window dropped, next result 16+2 after release.
    run_const(4096, 8191, 0, 4095, 1);
    while ((k - 2) % N != 7) step(1'b0, 4096, 8191, 0, 4095);
    step(1'b1, 4096, 8191, 0, NO_LIT);
    step(1'b1, 4096, 8191, 0, NO_LIT);
    for (int c = 0; c < LATENCY + N; c++) step(1'b0, 4096, 8191, 0, 4095);

    step(1'b1, 0, 0, 0, NO_LIT);
    for (int c = 0; c < LATENCY + N*40; c++) begin
      if (c == 301) step(1'b1, rnd14(), rnd14(), rnd14(), NO_LIT);
      else          step(1'b0, rnd14(), rnd14(), rnd14(), NO_LIT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
